// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU initiator: opcodes, packet lengths,
// FSM states and the request-packet byte selector.
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    localparam int         REQ_LEN       = 12;
    localparam int         RSP_LEN       = 4;
    localparam logic [7:0] RESERVED_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Request layout: opcode, reserved, 16-bit length (LE), A (LE), B (LE).
    function automatic logic [7:0] packet_byte(
        input logic [7:0]  opcode,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [3:0]  idx
    );
        logic [7:0] byte_sel;
        case (idx)
            4'd0:    byte_sel = opcode;
            4'd1:    byte_sel = RESERVED_BYTE;
            4'd2:    byte_sel = 8'(REQ_LEN);
            4'd3:    byte_sel = 8'h00;
            4'd4:    byte_sel = a[7:0];
            4'd5:    byte_sel = a[15:8];
            4'd6:    byte_sel = a[23:16];
            4'd7:    byte_sel = a[31:24];
            4'd8:    byte_sel = b[7:0];
            4'd9:    byte_sel = b[15:8];
            4'd10:   byte_sel = b[23:16];
            4'd11:   byte_sel = b[31:24];
            default: byte_sel = 8'h00;
        endcase
        return byte_sel;
    endfunction

endpackage

// File: rtl/uart_alu_initiator.sv
// Host-side UART ALU initiator: serialises one command into a 12-byte request
// and assembles the 4-byte little-endian response, with an rx-silence timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a command; stray rx bytes are flushed
// SEND     | streaming request bytes to the UART transmitter
// WAIT_RSP | collecting result bytes, timeout counter running
// RESP     | response held for the consumer; rx backpressured
module uart_alu_initiator
    import uart_alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 30000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_opcode_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        busy_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    // Comparing against the pre-increment value lets the abort happen on the
    // same edge the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [3:0]       REQ_LAST = 4'(REQ_LEN - 1);
    localparam logic [3:0]       RSP_LAST = 4'(RSP_LEN - 1);

    state_t           state_q;
    logic [3:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       opcode_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      result_q;

    assign rsp_data_o = result_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            opcode_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            result_q      <= '0;
            cmd_ready_o   <= 1'b1;
            tx_data_o     <= '0;
            tx_valid_o    <= 1'b0;
            rx_ready_o    <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        opcode_q    <= cmd_opcode_i;
                        a_q         <= cmd_a_i;
                        b_q         <= cmd_b_i;
                        idx_q       <= '0;
                        tx_data_o   <= packet_byte(cmd_opcode_i, cmd_a_i, cmd_b_i, 4'd0);
                        tx_valid_o  <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state_q     <= SEND;
                    end
                end

                SEND: begin
                    if (tx_valid_o && tx_ready_i) begin
                        if (idx_q == REQ_LAST) begin
                            tx_valid_o <= 1'b0;
                            idx_q      <= '0;
                            cnt_q      <= '0;
                            state_q    <= WAIT_RSP;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            tx_data_o <= packet_byte(opcode_q, a_q, b_q, idx_q + 4'd1);
                        end
                    end
                end

                WAIT_RSP: begin
                    // A byte arriving on the limit cycle takes priority over the abort.
                    if (rx_valid_i && rx_ready_o) begin
                        result_q[{idx_q[1:0], 3'b000} +: 8] <= rx_data_i;
                        cnt_q <= '0;
                        if (idx_q == RSP_LAST) begin
                            idx_q         <= '0;
                            rsp_valid_o   <= 1'b1;
                            rsp_timeout_o <= 1'b0;
                            rx_ready_o    <= 1'b0;
                            state_q       <= RESP;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q         <= cnt_q + 1'b1;
                        idx_q         <= '0;
                        rsp_valid_o   <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rx_ready_o    <= 1'b0;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        result_q      <= '0;
                        rsp_valid_o   <= 1'b0;
                        rsp_timeout_o <= 1'b0;
                        rx_ready_o    <= 1'b1;
                        cmd_ready_o   <= 1'b1;
                        busy_o        <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_initiator.sv
// Directed bench for uart_alu_initiator: request serialisation, response
// assembly, stalls, timeout, backpressure, stale-byte flush and mid-packet reset.
module tb_uart_alu_initiator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_opcode_i;
    logic [31:0] cmd_a_i;
    logic [31:0] cmd_b_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    uart_alu_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_opcode_i  (cmd_opcode_i),
        .cmd_a_i       (cmd_a_i),
        .cmd_b_i       (cmd_b_i),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one edge; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        check("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = op;
        cmd_a_i      = a;
        cmd_b_i      = b;
        tick();
        cmd_valid_i  = 1'b0;
        check("tx_valid_lat1", 32'(tx_valid_o), 32'd1);
        check("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
    endtask

    // exp holds the 12 request bytes, first byte in the top 8 bits.
    task automatic collect_tx(input string tag, input logic [95:0] exp, input bit stall);
        int         n = 0;
        int         stable_bad = 0;
        bit         was_stalled = 1'b0;
        logic [7:0] held = 8'h00;
        for (int cyc = 0; cyc < 200 && n < 12; cyc++) begin
            tx_ready_i = stall ? (cyc % 3 == 0) : 1'b1;
            if (was_stalled && tx_data_o !== held) stable_bad++;
            if (tx_valid_o && tx_ready_i) begin
                check({tag, "_byte"}, 32'(tx_data_o), 32'(exp[95 - 8*n -: 8]));
                n++;
                was_stalled = 1'b0;
            end else begin
                was_stalled = tx_valid_o;
                held        = tx_data_o;
            end
            tick();
        end
        tx_ready_i = 1'b0;
        check({tag, "_count"}, 32'(n), 32'd12);
        check({tag, "_stable"}, 32'(stable_bad), 32'd0);
        check({tag, "_tx_done"}, 32'(tx_valid_o), 32'd0);
    endtask

    // bytes: sent first-to-last from the top 8 bits down.
    task automatic feed_rx(input logic [31:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i  = bytes[31 - 8*i -: 8];
            tick();
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int rx_bad;
        int data_bad;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_opcode_i = '0; cmd_a_i = '0; cmd_b_i = '0;
        tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; rsp_ready_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data", rsp_data_o, 32'h0);
        check("rst_timeout", 32'(rsp_timeout_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rx_ready", 32'(rx_ready_o), 32'd1);

        // ADD 5 + 7
        send_cmd(8'hAD, 32'h0000_0005, 32'h0000_0007);
        check("add_busy", 32'(busy_o), 32'd1);
        collect_tx("add", 96'hAD000C00_05000000_07000000, 1'b0);
        feed_rx(32'h0C000000, 4);
        check("add_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("add_rsp_data", rsp_data_o, 32'h0000_000C);
        check("add_timeout", 32'(rsp_timeout_o), 32'd0);
        finish_rsp("add");

        // MUL with a stalling transmitter, then 20 cycles of response backpressure
        send_cmd(8'h88, 32'h1234_5678, 32'h0000_0002);
        collect_tx("mul", 96'h88000C00_78563412_02000000, 1'b1);
        feed_rx(32'hF0AC6824, 4);
        check("mul_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("mul_rsp_data", rsp_data_o, 32'h2468_ACF0);
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h99;
        rx_bad = 0;
        data_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_ready_o !== 1'b0) rx_bad++;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h2468_ACF0 || rsp_timeout_o !== 1'b0)
                data_bad++;
        end
        rx_valid_i = 1'b0;
        check("bp_rx_ready_low", 32'(rx_bad), 32'd0);
        check("bp_rsp_stable", 32'(data_bad), 32'd0);
        finish_rsp("mul");
        check("mul_rx_ready_back", 32'(rx_ready_o), 32'd1);

        // Timeout after two of four response bytes
        send_cmd(8'hD1, 32'h0000_0008, 32'h0000_0002);
        collect_tx("div", 96'hD1000C00_08000000_02000000, 1'b0);
        feed_rx(32'hAABB0000, 2);
        for (int i = 0; i < 14; i++) tick();
        check("to_not_yet", 32'(rsp_valid_o), 32'd0);
        check("to_busy_wait", 32'(busy_o), 32'd1);
        tick();
        check("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("to_flag", 32'(rsp_timeout_o), 32'd1);
        check("to_partial", rsp_data_o, 32'h0000_BBAA);
        finish_rsp("to");
        check("to_flag_clr", 32'(rsp_timeout_o), 32'd0);
        check("to_data_clr", rsp_data_o, 32'h0);

        // Stale rx byte in IDLE must not land in the next response
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h55;
        tick();
        rx_valid_i = 1'b0;
        send_cmd(8'hEC, 32'h0000_0011, 32'h0000_0022);
        collect_tx("echo", 96'hEC000C00_11000000_22000000, 1'b0);
        feed_rx(32'h01020304, 4);
        check("stale_rsp_data", rsp_data_o, 32'h0403_0201);
        finish_rsp("stale");

        // Reset while byte 6 (A[23:16]) is on the wire
        send_cmd(8'hAD, 32'h1234_5678, 32'h0000_0002);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        tx_ready_i = 1'b0;
        check("mid_byte6", 32'(tx_data_o), 32'h34);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        send_cmd(8'h88, 32'h1234_5678, 32'h0000_0002);
        collect_tx("restart", 96'h88000C00_78563412_02000000, 1'b0);
        feed_rx(32'hF0AC6824, 4);
        check("restart_rsp", rsp_data_o, 32'h2468_ACF0);
        finish_rsp("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
